ksa: RTL
========

// Module: ksa
// PURPOSE
//  RC4 key-scheduling stage; runs directly upstream of the PRGA stage over the shared 256x8 S memory.
//  Permutes S in place from the secret key:
//    for i in 0..255: j = j + S[i] + key[i mod KEY_BYTES]; swap(S[i], S[j]).
//  Start/finish use the same en/rdy handshake as the PRGA stage, so the top-level controller sequences both.
// PARAMETERS
//  KEY_BYTES  3  key length in bytes (1..32); key port width = 8*KEY_BYTES
// PORTS
//  clk       in   1             single clock, all state on posedge
//  rst       in   1             synchronous, active-high reset
//  en        in   1             start request; accepted only when rdy=1
//  rdy       out  1             1 = idle, ready to accept en
//  key       in   8*KEY_BYTES   key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB first); held stable while rdy=0
//  s_addr    out  8             S memory address
//  s_rddata  in   8             S read data; synchronous RAM, valid 1 cycle after s_addr
//  s_wrdata  out  8             S write data
//  s_wren    out  1             S write enable
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - state=IDLE, rdy=1, s_wren=0, s_addr=0, s_wrdata=0, i=0, j=0, kidx=0.
//    - Reset mid-operation aborts with the same values next edge; S contents are then undefined.
//  - Handshake:
//    - en sampled at posedge only when rdy=1.
//    - On acceptance: rdy<=0, i<=0, j<=0, kidx<=0, state<=FILL (KSA_INIT_EN) or RD_I.
//    - en while rdy=0 is ignored; there is no restart.
//  - Outputs are combinational from state and registers. IDLE drives all memory outputs to 0.
//  - FSM, 4 cycles per iteration:
//    - RD_I: s_addr=i, s_wren=0.
//    - RD_J:
//      - jn = j + s_rddata + keybyte[kidx], all mod 256.
//      - Drive s_addr=jn; register si<=s_rddata and j<=jn.
//    - WR_I: s_addr=i, s_wrdata=s_rddata (=S[j]), s_wren=1.
//    - WR_J: s_addr=j, s_wrdata=si, s_wren=1. Then:
//      - if i==255: state<=IDLE, rdy<=1.
//      - otherwise: i<=i+1, kidx<=(kidx==KEY_BYTES-1)?0:kidx+1, state<=RD_I.
//  - Arithmetic: i, j and addresses are 8-bit and wrap mod 256. kidx is a counter, not a divider.
//  - Boundary i==j: WR_I then WR_J write the same value to the same address; net S unchanged. Legal, no special case.
//  - Latency: rdy returns to 1 exactly 1024 cycles after the accepting edge (1280 with KSA_INIT_EN).
//  - Write count per run: exactly 512 s_wren cycles (768 with KSA_INIT_EN).
//  - Two writes are never back-to-back to the same address, except the i==j case.
//  - rdy=1 for exactly one cycle before a new en can be accepted.
// CONFIGURATION
//  - KSA_INIT_EN defined:
//    - Accepting en enters FILL: 256 cycles with s_addr=n, s_wrdata=n, s_wren=1 for n=0..255.
//    - After n=255, go to RD_I with i=j=kidx=0.
//    - The block alone produces the full KSA from arbitrary S contents.
//  - KSA_INIT_EN undefined:
//    - No FILL state exists.
//    - S must already hold the identity permutation (separate init stage); otherwise the result is undefined.
// TESTING
//  1. Reset: hold rst=1 for 2 cycles -> rdy=1, s_wren=0, s_addr=0, s_wrdata=0.
//  2. Identity S, key=24'h000000, en pulse -> rdy low for 1024 cycles.
//     Final S matches the C model byte-for-byte; 512 write cycles counted.
//  3. Identity S, key=24'h1E4600 -> final S matches the model. Confirms the MSB-first key byte order and kidx wrap at 3.
//  4. First iteration with key=24'h000000: j=0=i (self-swap).
//     Check WR_I and WR_J both write addr 0 with data 0, and S[0]=0 afterwards.
//  5. Assert en at cycles 5 and 500 of a run -> no restart; rdy returns at cycle 1024; S equals the single-run result.
//  6. Assert rst at iteration 100 (cycle ~400) -> next edge rdy=1, s_wren=0.
//     A subsequent en with an identity-reloaded S gives the correct final S.
//  7. (KSA_INIT_EN) Garbage-filled S, key=24'h000000 -> first 256 cycles write addr n / data n.
//     Result equals test 2; rdy returns at cycle 1280.

Source files
------------

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes the shared 256x8 S memory in place from the key, 4 cycles per index.
// Optional `define KSA_INIT_EN adds a 256-cycle identity fill of S before scheduling starts.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren
);

`ifdef KSA_INIT_EN
  typedef enum logic [2:0] {IDLE, FILL, RD_I, RD_J, WR_I, WR_J} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD_I, RD_J, WR_I, WR_J} state_t;
`endif

  localparam logic [4:0] KLAST = 5'(KEY_BYTES - 1);

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [4:0] kidx_q, kidx_d;
  logic [7:0] keybyte;
  logic [7:0] jn;

  // Byte 0 of the key sits in the most significant byte lane.
  always_comb begin
    keybyte = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == 5'(k)) keybyte = key[8*(KEY_BYTES-1-k) +: 8];
    end
  end

  assign jn = j_q + s_rddata + keybyte;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    kidx_d   = kidx_q;
    rdy      = (state_q == IDLE);
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
`ifdef KSA_INIT_EN
          state_d = FILL;
`else
          state_d = RD_I;
`endif
        end
      end
`ifdef KSA_INIT_EN
      // i doubles as the fill counter; it is back at 0 when scheduling begins.
      FILL: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = RD_I;
      end
`endif
      RD_I: begin
        s_addr  = i_q;
        state_d = RD_J;
      end
      RD_J: begin
        s_addr  = jn;
        si_d    = s_rddata;
        j_d     = jn;
        state_d = WR_I;
      end
      WR_I: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        if (i_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KLAST) ? 5'd0 : kidx_q + 5'd1;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      kidx_q  <= kidx_d;
    end
  end

endmodule
